// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line encoder: paces bits with a clock-divided timer, NRZI-encodes
// each bit onto D+/D- and terminates the packet with SE0,SE0,J before returning to idle J.
module usb_tx_line_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_start,
  input  logic tx_bit,
  input  logic stuff_flag,
  input  logic tx_eop,
  output logic shift,
  output logic dplus,
  output logic dminus,
  output logic tx_active,
  output logic eop_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_EOP_SE0 = 2'd2,
    ST_EOP_J   = 2'd3
  } state_e;

  // Line encoding is {dplus, dminus}.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sub_q, sub_d;
  line_e         line_q, line_d;
  logic          eop_done_q, eop_done_d;
  logic          at_boundary;

  assign at_boundary = (timer_q == LAST_TICK);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      sub_q      <= 1'b0;
      line_q     <= LINE_J;
      eop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sub_q      <= sub_d;
      line_q     <= line_d;
      eop_done_q <= eop_done_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through the
  // case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = at_boundary ? '0 : timer_q + TW'(1);
    sub_d      = sub_q;
    line_d     = line_q;
    eop_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        sub_d   = 1'b0;
        line_d  = LINE_J;
        if (tx_start) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (at_boundary) begin
          if (tx_eop) begin
            state_d = ST_EOP_SE0;
            sub_d   = 1'b0;
            line_d  = LINE_SE0;
          end else if (stuff_flag || !tx_bit) begin
            // NRZI: a zero (including a stuffed zero) toggles J<->K.
            line_d = (line_q == LINE_J) ? LINE_K : LINE_J;
          end
        end
      end
      ST_EOP_SE0: begin
        if (at_boundary) begin
          if (sub_q) begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
          end else begin
            sub_d = 1'b1;
          end
        end
      end
      ST_EOP_J: begin
        if (at_boundary) begin
          state_d    = ST_IDLE;
          eop_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = LINE_J;
      end
    endcase
  end

  // Shift is combinational so the upstream stages advance in the boundary cycle itself.
  always_comb begin
    tx_active = (state_q != ST_IDLE);
    shift     = 1'b0;
    if (state_q == ST_ACTIVE && at_boundary && !tx_eop) shift = 1'b1;
  end

  assign dplus    = line_q[1];
  assign dminus   = line_q[0];
  assign eop_done = eop_done_q;

endmodule
